// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: turn sequencer for an N x N board game (1P vs AI or 2P local),
// with a circular move history for repeated undo. Optional turn timeout: TURN_TIMER_EN.
module game_turn_ctrl #(
  parameter int          BOARD_N     = 15,
  parameter int          COORD_W     = 4,
  parameter int          HIST_DEPTH  = 16,
  parameter logic [31:0] TURN_CYCLES = 32'd500_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_mode,
  input  logic               i_start,
  input  logic               i_surrender,
  input  logic               i_prestep,
  input  logic               i_move_valid,
  input  logic [COORD_W-1:0] i_move_x,
  input  logic [COORD_W-1:0] i_move_y,
  output logic               o_move_ready,
  output logic               o_ai_req,
  output logic [1:0]         o_ai_level,
  input  logic               i_ai_valid,
  input  logic [COORD_W-1:0] i_ai_x,
  input  logic [COORD_W-1:0] i_ai_y,
  output logic               o_place_valid,
  output logic [COORD_W-1:0] o_place_x,
  output logic [COORD_W-1:0] o_place_y,
  output logic               o_place_player,
  output logic               o_undo_valid,
  output logic [COORD_W-1:0] o_undo_x,
  output logic [COORD_W-1:0] o_undo_y,
  input  logic               i_judge_done,
  input  logic               i_judge_win,
  input  logic               i_judge_draw,
  output logic               o_player,
  output logic [2:0]         o_state,
  output logic [1:0]         o_winner,
  output logic [8:0]         o_move_cnt,
  output logic [31:0]        o_time_left
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LIM_W = COORD_W + 1;
  localparam logic [LIM_W-1:0] BOARD_LIM = LIM_W'(BOARD_N);
  localparam logic [8:0]       CELLS     = 9'(BOARD_N * BOARD_N);
  localparam logic [CNT_W-1:0] HIST_FULL = CNT_W'(HIST_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_AI    = 3'd2,
    S_JUDGE = 3'd3,
    S_UNDO  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               player_q, player_d;
  logic [1:0]         winner_q, winner_d;
  logic [8:0]         move_cnt_q, move_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, pop_idx;
  logic [CNT_W-1:0]   hist_cnt_q, hist_cnt_d;
  logic [COORD_W-1:0] hist_x_q [HIST_DEPTH];
  logic [COORD_W-1:0] hist_x_d [HIST_DEPTH];
  logic [COORD_W-1:0] hist_y_q [HIST_DEPTH];
  logic [COORD_W-1:0] hist_y_d [HIST_DEPTH];
  logic [1:0]         undo_rem_q, undo_rem_d;
  logic               place_valid_q, place_valid_d;
  logic [COORD_W-1:0] place_x_q, place_x_d, place_y_q, place_y_d;
  logic               place_player_q, place_player_d;
  logic               undo_valid_q, undo_valid_d;
  logic [COORD_W-1:0] undo_x_q, undo_x_d, undo_y_q, undo_y_d;
  logic               push;
  logic [COORD_W-1:0] push_x, push_y;
  logic               undo_ok, move_ready;
`ifdef TURN_TIMER_EN
  logic [31:0]        timer_q, timer_d;
`endif

  assign undo_ok    = i_prestep && (hist_cnt_q != '0);
  // Surrender and a valid undo both outrank a move in the same cycle.
  assign move_ready = (state_q == S_WAIT) && i_move_valid && !i_surrender && !undo_ok &&
                      ({1'b0, i_move_x} < BOARD_LIM) && ({1'b0, i_move_y} < BOARD_LIM);
  assign pop_idx    = wr_ptr_q - PTR_W'(1);

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    player_d       = player_q;
    winner_d       = winner_q;
    move_cnt_d     = move_cnt_q;
    wr_ptr_d       = wr_ptr_q;
    hist_cnt_d     = hist_cnt_q;
    hist_x_d       = hist_x_q;
    hist_y_d       = hist_y_q;
    undo_rem_d     = undo_rem_q;
    place_valid_d  = 1'b0;
    place_x_d      = place_x_q;
    place_y_d      = place_y_q;
    place_player_d = place_player_q;
    undo_valid_d   = 1'b0;
    undo_x_d       = undo_x_q;
    undo_y_d       = undo_y_q;
    push           = 1'b0;
    push_x         = '0;
    push_y         = '0;
`ifdef TURN_TIMER_EN
    timer_d        = timer_q;
`endif

    case (state_q)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          mode_d     = i_mode;
          hist_cnt_d = '0;
          wr_ptr_d   = '0;
          move_cnt_d = '0;
          winner_d   = 2'd0;
          player_d   = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef TURN_TIMER_EN
        if (timer_q != '0) timer_d = timer_q - 32'd1;
`endif
        if (i_surrender) begin
          winner_d = player_q ? 2'd1 : 2'd2;
          state_d  = S_OVER;
        end else if (undo_ok) begin
          undo_rem_d = ((mode_q == 2'd3) || (hist_cnt_q == CNT_W'(1))) ? 2'd1 : 2'd2;
          state_d    = S_UNDO;
        end else if (move_ready) begin
          push    = 1'b1;
          push_x  = i_move_x;
          push_y  = i_move_y;
          state_d = S_JUDGE;
        end
`ifdef TURN_TIMER_EN
        else if (timer_q <= 32'd1) begin
          winner_d = player_q ? 2'd1 : 2'd2;
          state_d  = S_OVER;
        end
`endif
      end
      S_AI: begin
        if (i_ai_valid) begin
          push    = 1'b1;
          push_x  = i_ai_x;
          push_y  = i_ai_y;
          state_d = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (i_judge_done) begin
          if (i_judge_win) begin
            winner_d = player_q ? 2'd2 : 2'd1;
            state_d  = S_OVER;
          end else if (i_judge_draw || (move_cnt_q == CELLS)) begin
            winner_d = 2'd3;
            state_d  = S_OVER;
          end else begin
            player_d = !player_q;
            state_d  = ((mode_q != 2'd3) && !player_q) ? S_AI : S_WAIT;
          end
        end
      end
      S_UNDO: begin
        undo_valid_d = 1'b1;
        undo_x_d     = hist_x_q[pop_idx];
        undo_y_d     = hist_y_q[pop_idx];
        wr_ptr_d     = pop_idx;
        hist_cnt_d   = hist_cnt_q - CNT_W'(1);
        move_cnt_d   = (move_cnt_q != '0) ? move_cnt_q - 9'd1 : move_cnt_q;
        player_d     = !player_q;
        undo_rem_d   = undo_rem_q - 2'd1;
        if (undo_rem_q == 2'd1) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    // Write pointer wraps, so a push when full overwrites the oldest entry.
    if (push) begin
      hist_x_d[wr_ptr_q] = push_x;
      hist_y_d[wr_ptr_q] = push_y;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      hist_cnt_d         = (hist_cnt_q == HIST_FULL) ? hist_cnt_q : hist_cnt_q + CNT_W'(1);
      move_cnt_d         = (move_cnt_q == 9'd511) ? move_cnt_q : move_cnt_q + 9'd1;
      place_valid_d      = 1'b1;
      place_x_d          = push_x;
      place_y_d          = push_y;
      place_player_d     = player_q;
    end

`ifdef TURN_TIMER_EN
    if ((state_d == S_WAIT) && (state_q != S_WAIT)) timer_d = TURN_CYCLES;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      player_q       <= 1'b0;
      winner_q       <= '0;
      move_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      hist_cnt_q     <= '0;
      undo_rem_q     <= '0;
      place_valid_q  <= 1'b0;
      place_x_q      <= '0;
      place_y_q      <= '0;
      place_player_q <= 1'b0;
      undo_valid_q   <= 1'b0;
      undo_x_q       <= '0;
      undo_y_q       <= '0;
`ifdef TURN_TIMER_EN
      timer_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      player_q       <= player_d;
      winner_q       <= winner_d;
      move_cnt_q     <= move_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      hist_cnt_q     <= hist_cnt_d;
      undo_rem_q     <= undo_rem_d;
      place_valid_q  <= place_valid_d;
      place_x_q      <= place_x_d;
      place_y_q      <= place_y_d;
      place_player_q <= place_player_d;
      undo_valid_q   <= undo_valid_d;
      undo_x_q       <= undo_x_d;
      undo_y_q       <= undo_y_d;
`ifdef TURN_TIMER_EN
      timer_q        <= timer_d;
`endif
    end
  end

  // History contents need no reset: hist_cnt_q alone defines what is valid.
  always_ff @(posedge i_clk) begin
    hist_x_q <= hist_x_d;
    hist_y_q <= hist_y_d;
  end

  assign o_move_ready   = move_ready;
  assign o_ai_req       = (state_q == S_AI);
  assign o_ai_level     = (mode_q == 2'd3) ? 2'd0 : mode_q;
  assign o_place_valid  = place_valid_q;
  assign o_place_x      = place_x_q;
  assign o_place_y      = place_y_q;
  assign o_place_player = place_player_q;
  assign o_undo_valid   = undo_valid_q;
  assign o_undo_x       = undo_x_q;
  assign o_undo_y       = undo_y_q;
  assign o_player       = player_q;
  assign o_state        = state_q;
  assign o_winner       = winner_q;
  assign o_move_cnt     = move_cnt_q;
`ifdef TURN_TIMER_EN
  assign o_time_left    = timer_q;
`else
  // No timer in this build; the parameter is kept so overrides stay legal.
  assign o_time_left    = TURN_CYCLES & 32'd0;
`endif

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Randomized scoreboard bench for game_turn_ctrl: a queue-based game model predicts
// every place/undo pulse and the turn/winner state after each action.
module tb_game_turn_ctrl;
  localparam int N  = 15;
  localparam int HD = 16;
  localparam int S_IDLE = 0, S_WAIT = 1, S_AI = 2, S_JUDGE = 3, S_UNDO = 4, S_OVER = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] i_mode = '0;
  logic       i_start = 0, i_surrender = 0, i_prestep = 0;
  logic       i_move_valid = 0, i_ai_valid = 0;
  logic [3:0] i_move_x = '0, i_move_y = '0, i_ai_x = '0, i_ai_y = '0;
  logic       i_judge_done = 0, i_judge_win = 0, i_judge_draw = 0;
  logic       o_move_ready, o_ai_req, o_place_valid, o_place_player, o_undo_valid, o_player;
  logic [1:0] o_ai_level, o_winner;
  logic [3:0] o_place_x, o_place_y, o_undo_x, o_undo_y;
  logic [2:0] o_state;
  logic [8:0] o_move_cnt;
  logic [31:0] o_time_left;

  game_turn_ctrl #(.BOARD_N(N), .COORD_W(4), .HIST_DEPTH(HD), .TURN_CYCLES(32'd10)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(i_mode), .i_start(i_start),
    .i_surrender(i_surrender), .i_prestep(i_prestep),
    .i_move_valid(i_move_valid), .i_move_x(i_move_x), .i_move_y(i_move_y),
    .o_move_ready(o_move_ready), .o_ai_req(o_ai_req), .o_ai_level(o_ai_level),
    .i_ai_valid(i_ai_valid), .i_ai_x(i_ai_x), .i_ai_y(i_ai_y),
    .o_place_valid(o_place_valid), .o_place_x(o_place_x), .o_place_y(o_place_y),
    .o_place_player(o_place_player),
    .o_undo_valid(o_undo_valid), .o_undo_x(o_undo_x), .o_undo_y(o_undo_y),
    .i_judge_done(i_judge_done), .i_judge_win(i_judge_win), .i_judge_draw(i_judge_draw),
    .o_player(o_player), .o_state(o_state), .o_winner(o_winner),
    .o_move_cnt(o_move_cnt), .o_time_left(o_time_left)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected board commands, in issue order.
  typedef struct packed {logic [3:0] x; logic [3:0] y; logic p;} ev_t;
  ev_t place_exp[$];
  ev_t undo_exp[$];

  always @(negedge clk) begin : monitor
    ev_t e;
    if (o_place_valid) begin
      if (place_exp.size() == 0) check("place_unexpected", o_place_valid, 0);
      else begin
        e = place_exp.pop_front();
        check("place_xyp", {o_place_x, o_place_y, o_place_player}, {e.x, e.y, e.p});
      end
    end
    if (o_undo_valid) begin
      if (undo_exp.size() == 0) check("undo_unexpected", o_undo_valid, 0);
      else begin
        e = undo_exp.pop_front();
        check("undo_xy", {o_undo_x, o_undo_y}, {e.x, e.y});
      end
    end
  end

  // Game model: move history as a bounded queue of {x,y}.
  int         m_state = S_IDLE, m_mode = 0, m_cnt = 0, m_winner = 0;
  bit         m_player = 0;
  logic [7:0] hist[$];

  task automatic model_push(input logic [3:0] x, input logic [3:0] y);
    hist.push_back({x, y});
    if (hist.size() > HD) void'(hist.pop_front());
    if (m_cnt < 511) m_cnt++;
  endtask

  task automatic do_start(input int mode);
    i_start = 1; i_mode = 2'(mode);
    m_mode = mode; m_player = 0; m_cnt = 0; m_winner = 0; hist.delete(); m_state = S_WAIT;
    @(negedge clk); i_start = 0;
    check("start_state", o_state, m_state);
    check("start_player", o_player, m_player);
    check("start_cnt", o_move_cnt, m_cnt);
    check("start_winner", o_winner, m_winner);
  endtask

  task automatic human_move(input logic [3:0] x, input logic [3:0] y);
    bit ok;
    ok = (x < N) && (y < N);
    i_move_valid = 1; i_move_x = x; i_move_y = y;
    #1;
    check("move_ready", o_move_ready, ok);
    if (ok) begin
      place_exp.push_back(ev_t'({x, y, m_player}));
      model_push(x, y);
      m_state = S_JUDGE;
    end
    @(negedge clk); i_move_valid = 0;
    check("move_state", o_state, m_state);
    check("move_cnt", o_move_cnt, m_cnt);
  endtask

  task automatic judge(input bit w, input bit d);
    i_judge_done = 1; i_judge_win = w; i_judge_draw = d;
    if (w) begin m_winner = m_player ? 2 : 1; m_state = S_OVER; end
    else if (d || m_cnt == N * N) begin m_winner = 3; m_state = S_OVER; end
    else begin
      m_player = !m_player;
      m_state = (m_mode != 3 && m_player) ? S_AI : S_WAIT;
    end
    @(negedge clk); i_judge_done = 0; i_judge_win = 0; i_judge_draw = 0;
    check("judge_state", o_state, m_state);
    check("judge_winner", o_winner, m_winner);
    check("judge_player", o_player, m_player);
  endtask

  task automatic ai_move(input logic [3:0] x, input logic [3:0] y);
    int k;
    k = $urandom_range(0, 3);
    // Human surrender/undo attempts while the AI thinks must be ignored.
    i_prestep = 1; i_surrender = 1;
    repeat (k) @(negedge clk);
    i_prestep = 0; i_surrender = 0;
    check("ai_req", o_ai_req, 1);
    check("ai_level", o_ai_level, m_mode);
    check("ai_state", o_state, S_AI);
    i_ai_valid = 1; i_ai_x = x; i_ai_y = y;
    place_exp.push_back(ev_t'({x, y, 1'b1}));
    model_push(x, y);
    m_state = S_JUDGE;
    @(negedge clk); i_ai_valid = 0;
    check("ai_move_state", o_state, m_state);
  endtask

  task automatic prestep();
    int n, k;
    logic [7:0] e;
    i_prestep = 1;
    n = (hist.size() == 0) ? 0 : ((m_mode == 3 || hist.size() == 1) ? 1 : 2);
    for (int i = 0; i < n; i++) begin
      e = hist.pop_back();
      undo_exp.push_back(ev_t'({e, 1'b0}));
      if (m_cnt > 0) m_cnt--;
      m_player = !m_player;
    end
    @(negedge clk); i_prestep = 0;
    k = 0;
    while (o_state != 3'(S_WAIT) && k < 8) begin @(negedge clk); k++; end
    check("undo_state", o_state, S_WAIT);
    check("undo_cnt", o_move_cnt, m_cnt);
    check("undo_player", o_player, m_player);
  endtask

  task automatic surrender(input bit with_pre);
    i_surrender = 1; i_prestep = with_pre;
    m_winner = m_player ? 1 : 2; m_state = S_OVER;
    @(negedge clk); i_surrender = 0; i_prestep = 0;
    check("surr_state", o_state, m_state);
    check("surr_winner", o_winner, m_winner);
  endtask

  task automatic rand_judge();
    bit w, d;
    w = ($urandom_range(0, 29) == 0);
    d = !w && ($urandom_range(0, 39) == 0);
    judge(w, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_state", o_state, S_IDLE);
    check("rst_winner", o_winner, 0);
    check("rst_cnt", o_move_cnt, 0);
    check("rst_outs", {o_place_valid, o_undo_valid, o_ai_req, o_player, o_move_ready}, 0);
    check("rst_time", o_time_left, 0);

    // 2P: first move and turn hand-over
    do_start(3);
    human_move(4'd7, 4'd7);
    judge(0, 0);
    check("p2_player_after_1", o_player, 1);

    // start is ignored while a game runs
    i_start = 1; i_mode = 2'd0;
    @(negedge clk); i_start = 0;
    check("start_ignored_state", o_state, S_WAIT);
    check("start_ignored_cnt", o_move_cnt, m_cnt);

    // surrender beats prestep, white resigns -> black wins, no undo
    surrender(1);
    check("surr_black_wins", o_winner, 1);

    // 1P normal: human, AI, then undo both
    do_start(1);
    human_move(4'd3, 4'd4);
    judge(0, 0);
    ai_move(4'd5, 4'd5);
    judge(0, 0);
    check("p1_cnt2", o_move_cnt, 2);
    prestep();
    check("p1_undo_cnt", o_move_cnt, 0);
    check("p1_undo_player", o_player, 0);
    prestep();  // empty history: ignored
    surrender(0);

    // 2P history wrap: 20 moves, 17 undos
    do_start(3);
    for (int i = 0; i < 20; i++) begin
      human_move(4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1)));
      judge(0, 0);
    end
    for (int i = 0; i < 17; i++) prestep();
    check("wrap_cnt", o_move_cnt, 4);
    human_move(4'd15, 4'd3);
    human_move(4'd2, 4'd15);
    surrender(0);

    // explicit draw verdict
    do_start(3);
    human_move(4'd0, 4'd14);
    judge(0, 1);

    // full board forces a draw
    do_start(3);
    for (int i = 0; i < N * N; i++) begin
      human_move(4'(i % N), 4'(i / N));
      judge(0, 0);
    end
    check("full_winner", o_winner, 3);
    check("full_cnt", o_move_cnt, N * N);

    // random games
    for (int g = 0; g < 6; g++) begin
      do_start($urandom_range(0, 3));
      for (int t = 0; t < 80 && m_state != S_OVER; t++) begin
        if (m_state == S_AI) begin
          ai_move(4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1)));
          rand_judge();
        end else begin
          r = $urandom_range(0, 19);
          if (r == 0) surrender(0);
          else if (r < 4) prestep();
          else if (r == 4) human_move(4'd15, 4'($urandom_range(0, N - 1)));
          else begin
            human_move(4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1)));
            rand_judge();
          end
        end
      end
      if (m_state == S_AI) begin ai_move(4'd1, 4'd1); judge(1, 0); end
      else if (m_state == S_WAIT) surrender(0);
    end

    // reset mid-move: no place pulse may follow
    do_start(2);
    i_move_valid = 1; i_move_x = 4'd7; i_move_y = 4'd7; rst = 1;
    @(negedge clk);
    i_move_valid = 0; rst = 0;
    m_state = S_IDLE; m_cnt = 0; m_player = 0; m_winner = 0; hist.delete();
    check("midrst_state", o_state, S_IDLE);
    check("midrst_place", o_place_valid, 0);
    check("midrst_cnt", o_move_cnt, 0);
    check("midrst_winner", o_winner, 0);

`ifdef TURN_TIMER_EN
    do_start(3);
    check("timer_load", o_time_left, 10);
    repeat (9) @(negedge clk);
    check("timer_before_expiry", o_state, S_WAIT);
    check("timer_left_1", o_time_left, 1);
    @(negedge clk);
    check("timeout_state", o_state, S_OVER);
    check("timeout_winner", o_winner, 2);
`else
    check("time_left_tied", o_time_left, 0);
`endif

    repeat (3) @(negedge clk);
    check("place_drained", place_exp.size(), 0);
    check("undo_drained", undo_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_turn_ctrl.md
Name: game_turn_ctrl

Overview:
- Parametrised successor to the single-state game controller. Sequences turns for an N×N board game.
- Supports 1P play against the AI engine at difficulty 0–2, and 2P local play.
- Arbitrates human moves, AI moves, surrender and undo (prestep). Issues placement and undo commands to the board memory and consumes the judge's win/draw verdict.
- Holds a circular move-history stack so undo can be repeated up to HIST_DEPTH moves.

Parameters:
- BOARD_N, 15, board side length; coordinates are 0..BOARD_N-1.
- COORD_W, 4, coordinate width; must satisfy 2**COORD_W >= BOARD_N.
- HIST_DEPTH, 16, history entries; power of two, >=2.
- TURN_CYCLES, 32'd500_000_000, per-turn time limit in clocks (TURN_TIMER_EN only).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_mode  in  2  0/1/2 = 1P easy/normal/hard, 3 = 2P; sampled on i_start only
- i_start  in  1  start pulse, honoured in S_IDLE and S_OVER
- i_surrender  in  1  current human player resigns
- i_prestep  in  1  undo request
- i_move_valid/i_move_x/i_move_y  in  1/COORD_W/COORD_W  human move
- o_move_ready  out  1  human move accepted this cycle
- o_ai_req  out  1  level, AI must compute a move
- o_ai_level  out  2  latched mode when 1P
- i_ai_valid/i_ai_x/i_ai_y  in  1/COORD_W/COORD_W  AI move, one-cycle pulse
- o_place_valid/o_place_x/o_place_y/o_place_player  out  1/COORD_W/COORD_W/1  board write pulse
- o_undo_valid/o_undo_x/o_undo_y  out  1/COORD_W/COORD_W  board clear pulse
- i_judge_done/i_judge_win/i_judge_draw  in  1/1/1  verdict for the last placement
- o_player  out  1  side to move (0 = black, moves first)
- o_state  out  3  current FSM state
- o_winner  out  2  0 none, 1 black, 2 white, 3 draw
- o_move_cnt  out  9  stones on board
- o_time_left  out  32  remaining turn cycles

Behaviour:
- Reset values: all outputs 0; state S_IDLE; history empty.
- States: S_IDLE=0, S_WAIT=1 (human to move), S_AI=2, S_JUDGE=3, S_UNDO=4, S_OVER=5.
- S_IDLE/S_OVER + i_start: latch mode; clear history, o_move_cnt, o_winner; set o_player=0; go to S_WAIT. In 1P the human is black.
- S_WAIT, priority per cycle is surrender > prestep > move.
  - Surrender: o_winner = opponent of o_player; go to S_OVER.
  - Prestep with history count > 0: go to S_UNDO.
  - Prestep with empty history: ignored.
- S_WAIT + i_move_valid, in range: o_move_ready=1; o_place_* pulses the same cycle (combinational accept, registered outputs next cycle allowed = 1-cycle latency); push (x,y); go to S_JUDGE. Out-of-range coordinates: not ready, ignored.
- S_AI: o_ai_req=1. On i_ai_valid: place, push, go to S_JUDGE. Surrender/prestep are ignored in S_AI.
- S_JUDGE: wait for i_judge_done.
  - win: o_winner = mover+1, go to S_OVER.
  - else draw, or o_move_cnt == BOARD_N²: o_winner=3, go to S_OVER.
  - else toggle o_player. Next state is S_AI if 1P and o_player becomes 1, otherwise S_WAIT.
- S_UNDO: pop count = 2 in 1P (human + AI), 1 in 2P, clipped to history count.
  - One o_undo_valid pulse per popped entry, on consecutive cycles, newest first.
  - o_move_cnt decrements per pop; o_player toggles per pop. In 1P the net result is black to move.
  - Then go to S_WAIT.
- History is circular. A push when full overwrites the oldest entry; count saturates at HIST_DEPTH. Undo is therefore limited to the last HIST_DEPTH moves.
- o_move_cnt saturates at 511; it never underflows.
- i_start outside S_IDLE/S_OVER is ignored. i_rst during any state returns to reset values on the next edge, with no pending place/undo pulse.

Optional Feature:
- TURN_TIMER_EN defined:
  - Timer loads TURN_CYCLES on entry to S_WAIT and decrements each cycle in S_WAIT; o_time_left shows its value.
  - On reaching 0 with no accepted move, the mover loses: o_winner = opponent, go to S_OVER.
  - A move accepted in the same cycle as expiry wins over expiry.
  - Timer is frozen in all other states.
- Undefined: no timeout; o_time_left tied to 0.

Test Plan:
- Reset, i_start with mode=3, black moves (7,7) -> o_place_valid 1 pulse at (7,7), player 0; judge done no-win -> o_player=1, state S_WAIT, o_move_cnt=1.
- Mode=1, human (3,4), judge ok -> o_ai_req=1, o_ai_level=1; AI (5,5) -> place player 1; judge ok -> S_WAIT, o_move_cnt=2.
- After the previous scenario, i_prestep -> two o_undo_valid pulses, (5,5) then (3,4); o_move_cnt=0; o_player=0.
- Mode=3, push 20 moves with HIST_DEPTH=16, then 17 presteps -> 16 undo pulses; 17th ignored; o_move_cnt=4.
- i_surrender and i_prestep in the same cycle with player 1 -> o_winner=1, S_OVER, no undo pulse.
- TURN_TIMER_EN with TURN_CYCLES=10, no move -> after 10 cycles o_winner=2 (black timed out), S_OVER.
